// File: rtl/casex_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : casex_slot_sequencer
// Description : Samples a selector while idle and finds the first matching
//               entry in a small programmable don't-care pattern table. It
//               then runs one update slot for that entry: a fixed setup
//               delay, a registered output update with a one-cycle pulse,
//               and a fixed hold delay before the selector is sampled again.
// Revision    : 1.0 - initial release
// ============================================================================
module casex_slot_sequencer #(
    parameter int WIDTH   = 4,  // selector / pattern / result width
    parameter int ENTRIES = 3,  // pattern table depth (1..4)
    parameter int SETUP   = 3,  // cycles from sample to output update (>=1)
    parameter int HOLD    = 3   // cycles output is held before resampling (>=1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sel,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_idx,
    input  logic [WIDTH-1:0] cfg_pat,
    input  logic [WIDTH-1:0] cfg_care,
    input  logic [WIDTH-1:0] cfg_res,
    output logic [WIDTH-1:0] value_out,
    output logic             upd,
    output logic             miss,
    output logic             busy,
    output logic [1:0]       hit_idx
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int MAX_DLY = (SETUP > HOLD) ? SETUP : HOLD;
    localparam int CNT_W   = $clog2(MAX_DLY) + 1;

    // The counter runs from N-1 down to 0, so each phase lasts N cycles.
    localparam logic [CNT_W-1:0] C_SETUP_LOAD = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LOAD  = CNT_W'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Table reset contents. e1 leaves bit 1 as don't-care (00x1); entries
    // beyond the programmed defaults compare all bits against all-ones.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] rst_pat(input int idx);
        case (idx)
            0:       return '0;
            1:       return WIDTH'(1);
            2:       return WIDTH'(4);
            default: return '1;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] rst_care(input int idx);
        case (idx)
            1:       return ~WIDTH'(2);
            default: return '1;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] rst_res(input int idx);
        case (idx)
            1:       return WIDTH'(1);
            2:       return WIDTH'(2);
            default: return '0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] res_lat_q, res_lat_d;
    logic [WIDTH-1:0] value_q,   value_d;
    logic             upd_q,     upd_d;
    logic             miss_q,    miss_d;
    logic [1:0]       hit_idx_q, hit_idx_d;

    logic [WIDTH-1:0] pat_q  [ENTRIES];
    logic [WIDTH-1:0] pat_d  [ENTRIES];
    logic [WIDTH-1:0] care_q [ENTRIES];
    logic [WIDTH-1:0] care_d [ENTRIES];
    logic [WIDTH-1:0] res_q  [ENTRIES];
    logic [WIDTH-1:0] res_d  [ENTRIES];

    // ------------------------------------------------------------------
    // Match logic
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] hit_vec;
    logic               any_hit;
    logic [1:0]         first_idx;
    logic [WIDTH-1:0]   first_res;

    // Per-entry wildcard compare against the registered table contents, so a
    // write landing in the sample cycle does not influence that sample.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
        assign hit_vec[gi] = (((sel ^ pat_q[gi]) & care_q[gi]) == '0);
    end

    // Priority select: scanning from the top down, the last hit assigned is
    // the lowest index, which is the one that wins.
    always_comb begin
        any_hit   = 1'b0;
        first_idx = 2'd0;
        first_res = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit   = 1'b1;
                first_idx = 2'(i);
                first_res = res_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Table write path
    // ------------------------------------------------------------------
    // Writes land in any state; indices at or beyond ENTRIES match no entry
    // and are therefore dropped.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            pat_d[i]  = pat_q[i];
            care_d[i] = care_q[i];
            res_d[i]  = res_q[i];
            if (cfg_we && (int'(cfg_idx) == i)) begin
                pat_d[i]  = cfg_pat;
                care_d[i] = cfg_care;
                res_d[i]  = cfg_res;
            end
        end
    end

    // Table registers, restored to their default contents on reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                pat_q[i]  <= rst_pat(i);
                care_q[i] <= rst_care(i);
                res_q[i]  <= rst_res(i);
            end else begin
                pat_q[i]  <= pat_d[i];
                care_q[i] <= care_d[i];
                res_q[i]  <= res_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot sequencer
    // ------------------------------------------------------------------
    // Next-state and registered-output logic. The result and index are
    // latched at the sample, so selector or table changes mid-slot have no
    // effect on the slot in progress.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_lat_d = res_lat_q;
        value_d   = value_q;
        upd_d     = 1'b0;
        miss_d    = 1'b0;
        hit_idx_d = hit_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (any_hit) begin
                    res_lat_d = first_res;
                    hit_idx_d = first_idx;
                    cnt_d     = C_SETUP_LOAD;
                    state_d   = ST_SETUP;
                end else begin
                    miss_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    // Always reload, even if the value is unchanged, so the
                    // consumer sees one upd pulse per slot.
                    value_d = res_lat_q;
                    upd_d   = 1'b1;
                    cnt_d   = C_HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer registers. Reset aborts any slot in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            res_lat_q <= '0;
            value_q   <= '0;
            upd_q     <= 1'b0;
            miss_q    <= 1'b0;
            hit_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_lat_q <= res_lat_d;
            value_q   <= value_d;
            upd_q     <= upd_d;
            miss_q    <= miss_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign value_out = value_q;
    assign upd       = upd_q;
    assign miss      = miss_q;
    assign busy      = (state_q != ST_IDLE);
    assign hit_idx   = hit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_casex_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_casex_slot_sequencer
// Description : Directed self-checking bench for casex_slot_sequencer with a
//               scoreboard of expected dispatches popped on every upd pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_casex_slot_sequencer;

    localparam int WIDTH   = 4;
    localparam int ENTRIES = 3;
    localparam int SETUP   = 3;
    localparam int HOLD    = 3;
    localparam int SLOT    = 1 + SETUP + HOLD;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] sel;
    logic             cfg_we;
    logic [1:0]       cfg_idx;
    logic [WIDTH-1:0] cfg_pat;
    logic [WIDTH-1:0] cfg_care;
    logic [WIDTH-1:0] cfg_res;
    logic [WIDTH-1:0] value_out;
    logic             upd;
    logic             miss;
    logic             busy;
    logic [1:0]       hit_idx;

    typedef struct {
        logic [WIDTH-1:0] val;
        logic [1:0]       idx;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    casex_slot_sequencer #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .SETUP   (SETUP),
        .HOLD    (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_pat   (cfg_pat),
        .cfg_care  (cfg_care),
        .cfg_res   (cfg_res),
        .value_out (value_out),
        .upd       (upd),
        .miss      (miss),
        .busy      (busy),
        .hit_idx   (hit_idx)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 ns after the edge, and retire a scoreboard
    // entry whenever the DUT signals an update.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (upd === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("upd_value", 32'(value_out), 32'(e.val));
                chk("upd_idx",   32'(hit_idx),   32'(e.idx));
            end
        end
    endtask

    // Called in an IDLE cycle whose sample must hit. Runs the full slot and
    // ends in the following IDLE sample cycle. Any cfg write set up by the
    // caller is held only for the sample cycle.
    task automatic run_slot(input logic [WIDTH-1:0] exp_val, input logic [1:0] exp_idx,
                            input logic [WIDTH-1:0] sel_after);
        sb.push_back('{val: exp_val, idx: exp_idx});
        for (int k = 1; k <= SLOT; k++) begin
            tick();
            if (k == 1) begin
                sel    = sel_after;
                cfg_we = 1'b0;
                chk("slot_hit_idx", 32'(hit_idx), 32'(exp_idx));
            end
            chk("slot_busy", 32'(busy), 32'(k <= SETUP + HOLD));
            chk("slot_upd",  32'(upd),  32'(k == SETUP + 1));
            chk("slot_miss", 32'(miss), 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        sel      = '0;
        cfg_we   = 1'b0;
        cfg_idx  = 2'd0;
        cfg_pat  = '0;
        cfg_care = '0;
        cfg_res  = '0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state, observed in the first idle cycle.
        chk("rst_value", 32'(value_out), 32'd0);
        chk("rst_upd",   32'(upd),       32'd0);
        chk("rst_miss",  32'(miss),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_idx",   32'(hit_idx),   32'd0);

        // sel=0000 held: two back-to-back slots on e0.
        run_slot(4'h0, 2'd0, 4'h0);
        run_slot(4'h0, 2'd0, 4'h0);

        // e1 matches through its don't-care bit.
        sel = 4'h3;
        run_slot(4'h1, 2'd1, 4'h1);
        run_slot(4'h1, 2'd1, 4'h1);

        // Selector change right after the sample leaves the slot untouched.
        sel = 4'h3;
        run_slot(4'h1, 2'd1, 4'h4);
        run_slot(4'h2, 2'd2, 4'hF);

        // sel=1111 misses every cycle.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("miss_pulse", 32'(miss),      32'd1);
            chk("miss_busy",  32'(busy),      32'd0);
            chk("miss_value", 32'(value_out), 32'h2);
        end
        // Reprogram e0 as 1xxx; this cycle's sample still uses the old table.
        cfg_we   = 1'b1;
        cfg_idx  = 2'd0;
        cfg_pat  = 4'h8;
        cfg_care = 4'h8;
        cfg_res  = 4'hA;
        tick();
        cfg_we = 1'b0;
        chk("miss_old_table", 32'(miss), 32'd1);
        run_slot(4'hA, 2'd0, 4'h4);

        // sel=0100 hits e2; reset in the second SETUP cycle aborts it.
        tick();
        chk("abort_busy", 32'(busy),    32'd1);
        chk("abort_idx",  32'(hit_idx), 32'd2);
        tick();
        reset = 1'b1;
        tick();
        chk("abort_value", 32'(value_out), 32'd0);
        chk("abort_busy0", 32'(busy),      32'd0);
        chk("abort_upd",   32'(upd),       32'd0);
        chk("abort_idx0",  32'(hit_idx),   32'd0);
        reset = 1'b0;
        run_slot(4'h2, 2'd2, 4'h0);
        // Table defaults were restored by the reset: e0 is 0000 again.
        run_slot(4'h0, 2'd0, 4'h3);

        // Write to idx 3 (beyond ENTRIES) must be dropped.
        cfg_we   = 1'b1;
        cfg_idx  = 2'd3;
        cfg_pat  = 4'hF;
        cfg_care = 4'h0;
        cfg_res  = 4'hC;
        run_slot(4'h1, 2'd1, 4'h3);
        // Rewrite e1 in the same cycle as an e1 sample: old result goes out.
        cfg_we   = 1'b1;
        cfg_idx  = 2'd1;
        cfg_pat  = 4'h3;
        cfg_care = 4'hF;
        cfg_res  = 4'h7;
        run_slot(4'h1, 2'd1, 4'h3);
        run_slot(4'h7, 2'd1, 4'h1);
        // New e1 compares all bits, so 0001 now misses.
        tick();
        chk("new_e1_miss", 32'(miss), 32'd1);
        chk("new_e1_busy", 32'(busy), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
